axi4l_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one AXI4-Lite slave port between NUMM AXI4-Lite masters.

---
 rtl/axi4l_if.sv | 38 +++
 rtl/axi4l_rr_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_axi4l_rr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle; the master modport drives requests, the slave modport returns
// ready/response.
interface axi4l_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4l_rr_arbiter.sv
// Round-robin arbiter letting NUMM AXI4-Lite masters share one AXI4-Lite slave, one
// transaction in flight; the grant is held from address phase until the response handshake.
module axi4l_rr_arbiter #(
    parameter int NUMM = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    axi4l_if.slave                  axim [NUMM],
    axi4l_if.master                 axis,
    output logic [$clog2(NUMM)-1:0] grant,
    output logic                    busy
);
    localparam int GW = $clog2(NUMM);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WADDR = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_RADDR = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;

    logic [2:0]      state;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   win_idx;
    logic [GW-1:0]   next_ptr;
    logic [GW:0]     cand;
    logic            win_found;
    logic            aw_done;
    logic            w_done;

    logic [NUMM-1:0] req;
    logic [NUMM-1:0] m_awvalid;
    logic [NUMM-1:0] m_wvalid;
    logic [NUMM-1:0] m_bready;
    logic [NUMM-1:0] m_arvalid;
    logic [NUMM-1:0] m_rready;
    logic [AW-1:0]   m_awaddr [NUMM];
    logic [2:0]      m_awprot [NUMM];
    logic [DW-1:0]   m_wdata  [NUMM];
    logic [DW/8-1:0] m_wstrb  [NUMM];
    logic [AW-1:0]   m_araddr [NUMM];
    logic [2:0]      m_arprot [NUMM];

    logic st_waddr;
    logic st_wresp;
    logic st_raddr;
    logic st_rdata;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic aw_fin;
    logic w_fin;

    assign st_waddr = (state == ST_WADDR);
    assign st_wresp = (state == ST_WRESP);
    assign st_raddr = (state == ST_RADDR);
    assign st_rdata = (state == ST_RDATA);
    assign busy     = (state != ST_IDLE);

    // Gather master requests into arrays; only the granted port ever sees ready/valid back.
    for (genvar i = 0; i < NUMM; i++) begin : g_m
        logic sel;
        assign sel          = (grant == GW'(i));
        assign m_awvalid[i] = axim[i].awvalid;
        assign m_awaddr[i]  = axim[i].awaddr;
        assign m_awprot[i]  = axim[i].awprot;
        assign m_wvalid[i]  = axim[i].wvalid;
        assign m_wdata[i]   = axim[i].wdata;
        assign m_wstrb[i]   = axim[i].wstrb;
        assign m_bready[i]  = axim[i].bready;
        assign m_arvalid[i] = axim[i].arvalid;
        assign m_araddr[i]  = axim[i].araddr;
        assign m_arprot[i]  = axim[i].arprot;
        assign m_rready[i]  = axim[i].rready;
        assign req[i]       = axim[i].awvalid | axim[i].arvalid;

        assign axim[i].awready = sel & st_waddr & ~aw_done & axis.awready;
        assign axim[i].wready  = sel & st_waddr & ~w_done & axis.wready;
        assign axim[i].bvalid  = sel & st_wresp & axis.bvalid;
        assign axim[i].bresp   = (sel & st_wresp) ? axis.bresp : 2'b00;
        assign axim[i].arready = sel & st_raddr & axis.arready;
        assign axim[i].rvalid  = sel & st_rdata & axis.rvalid;
        assign axim[i].rdata   = (sel & st_rdata) ? axis.rdata : '0;
        assign axim[i].rresp   = (sel & st_rdata) ? axis.rresp : 2'b00;
    end

    always_comb begin
        axis.awvalid = 1'b0;
        axis.awaddr  = '0;
        axis.awprot  = 3'b000;
        axis.wvalid  = 1'b0;
        axis.wdata   = '0;
        axis.wstrb   = '0;
        axis.bready  = 1'b0;
        axis.arvalid = 1'b0;
        axis.araddr  = '0;
        axis.arprot  = 3'b000;
        axis.rready  = 1'b0;
        case (state)
            ST_WADDR: begin
                axis.awvalid = m_awvalid[grant] & ~aw_done;
                axis.awaddr  = m_awaddr[grant];
                axis.awprot  = m_awprot[grant];
                axis.wvalid  = m_wvalid[grant] & ~w_done;
                axis.wdata   = m_wdata[grant];
                axis.wstrb   = m_wstrb[grant];
            end
            ST_WRESP: axis.bready = m_bready[grant];
            ST_RADDR: begin
                axis.arvalid = m_arvalid[grant];
                axis.araddr  = m_araddr[grant];
                axis.arprot  = m_arprot[grant];
            end
            ST_RDATA: axis.rready = m_rready[grant];
            default: ;
        endcase
    end

    assign aw_hs  = axis.awvalid & axis.awready;
    assign w_hs   = axis.wvalid & axis.wready;
    assign b_hs   = st_wresp & axis.bvalid & axis.bready;
    assign ar_hs  = axis.arvalid & axis.arready;
    assign r_hs   = st_rdata & axis.rvalid & axis.rready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    assign next_ptr = (grant == GW'(NUMM - 1)) ? '0 : grant + 1'b1;

    // Rotating priority: the first requester at or after ptr, wrapping modulo NUMM.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = '0;
        for (int k = 0; k < NUMM; k++) begin
            cand = {1'b0, ptr} + (GW + 1)'(k);
            if (cand >= (GW + 1)'(NUMM)) cand = cand - (GW + 1)'(NUMM);
            if (!win_found && req[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            grant   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        grant <= win_idx;
                        state <= m_awvalid[win_idx] ? ST_WADDR : ST_RADDR;
                    end
                end
                ST_WADDR: begin
                    if (aw_fin && w_fin) begin
                        state   <= ST_WRESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_fin;
                        w_done  <= w_fin;
                    end
                end
                ST_WRESP: begin
                    if (b_hs) begin
                        state <= ST_IDLE;
                        ptr   <= next_ptr;
                    end
                end
                ST_RADDR: begin
                    if (ar_hs) state <= ST_RDATA;
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        state <= ST_IDLE;
                        ptr   <= next_ptr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    grant_in_range: assert property (@(posedge clk) disable iff (rst)
        {1'b0, grant} < (GW + 1)'(NUMM));
    flags_clear_outside_waddr: assert property (@(posedge clk) disable iff (rst)
        !st_waddr |-> (!aw_done && !w_done));

endmodule

// File: tb/tb_axi4l_rr_arbiter.sv
// Randomized bench for axi4l_rr_arbiter: three masters and a small RAM slave, checked against
// a transaction-level round-robin model with a shadow memory.
module tb_axi4l_rr_arbiter;
    localparam int NM = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    axi4l_if #(.AW(32), .DW(32)) m_if [NM] ();
    axi4l_if #(.AW(32), .DW(32)) s_if ();

    axi4l_rr_arbiter #(.NUMM(NM), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .axim  (m_if),
        .axis  (s_if),
        .grant (grant),
        .busy  (busy)
    );

    logic [NM-1:0] m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0]   m_awaddr [NM];
    logic [31:0]   m_wdata  [NM];
    logic [3:0]    m_wstrb  [NM];
    logic [31:0]   m_araddr [NM];
    logic [NM-1:0] o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [1:0]    o_bresp [NM];
    logic [1:0]    o_rresp [NM];
    logic [31:0]   o_rdata [NM];

    for (genvar g = 0; g < NM; g++) begin : g_m
        assign m_if[g].awvalid = m_awvalid[g];
        assign m_if[g].awaddr  = m_awaddr[g];
        assign m_if[g].awprot  = 3'b000;
        assign m_if[g].wvalid  = m_wvalid[g];
        assign m_if[g].wdata   = m_wdata[g];
        assign m_if[g].wstrb   = m_wstrb[g];
        assign m_if[g].bready  = m_bready[g];
        assign m_if[g].arvalid = m_arvalid[g];
        assign m_if[g].araddr  = m_araddr[g];
        assign m_if[g].arprot  = 3'b000;
        assign m_if[g].rready  = m_rready[g];
        assign o_awready[g]    = m_if[g].awready;
        assign o_wready[g]     = m_if[g].wready;
        assign o_bvalid[g]     = m_if[g].bvalid;
        assign o_bresp[g]      = m_if[g].bresp;
        assign o_arready[g]    = m_if[g].arready;
        assign o_rvalid[g]     = m_if[g].rvalid;
        assign o_rdata[g]      = m_if[g].rdata;
        assign o_rresp[g]      = m_if[g].rresp;
    end

    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    assign s_if.awready = s_awready;
    assign s_if.wready  = s_wready;
    assign s_if.bvalid  = s_bvalid;
    assign s_if.bresp   = s_bresp;
    assign s_if.arready = s_arready;
    assign s_if.rvalid  = s_rvalid;
    assign s_if.rdata   = s_rdata;
    assign s_if.rresp   = s_rresp;

    // slave-side bookkeeping
    bit          s_aw_got, s_w_got, s_b_pend, s_r_pend;
    int          s_b_dly, s_r_dly;
    logic [31:0] s_awaddr_l, s_wdata_l;
    logic [3:0]  s_wstrb_l;
    logic [31:0] s_mem [8];

    // master-side intent and the reference model
    bit          wr_pend [NM];
    bit          rd_pend [NM];
    int          wr_word [NM];
    int          rd_word [NM];
    logic [31:0] wr_data [NM];
    logic [3:0]  wr_strb [NM];
    int          b_wait  [NM];
    logic [31:0] ref_mem [8];
    int          mdl_ptr, mdl_owner, busy_cnt, n_done;
    bit          mdl_busy, mdl_write, just_arb;
    logic [1:0]  dut_grants [$];

    int pct_issue, pct_sready, pct_mready, kind_mode, b_hold, max_dly;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    task automatic clear_tb();
        m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
        for (int i = 0; i < NM; i++) begin
            m_awaddr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0; m_araddr[i] = '0;
            wr_pend[i] = 1'b0; rd_pend[i] = 1'b0; b_wait[i] = 0;
        end
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0;
        s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
        s_aw_got = 1'b0; s_w_got = 1'b0; s_b_pend = 1'b0; s_r_pend = 1'b0;
        mdl_ptr = 0; mdl_busy = 1'b0; just_arb = 1'b0; busy_cnt = 0;
    endtask

    // Reset is checked one edge after assertion while the slave still holds its outputs.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_up", 32'({o_awready, o_wready, o_arready, o_bvalid, o_rvalid}), 32'd0);
        chk("rst_up_data", o_rdata[0] | o_rdata[1] | o_rdata[2], 32'd0);
        chk("rst_down", 32'({s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready, s_if.rready}),
            32'd0);
        chk("rst_down_data", s_if.awaddr | s_if.araddr | s_if.wdata, 32'd0);
        @(posedge clk); #1;
        clear_tb();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step();
        bit            h_aw [NM];
        bit            h_w  [NM];
        bit            h_b  [NM];
        bit            h_ar [NM];
        bit            h_r  [NM];
        bit            c_bv [NM];
        bit            sh_aw, sh_w, sh_b, sh_ar, sh_r;
        logic [31:0]   c_awaddr, c_wdata, c_araddr;
        logic [3:0]    c_wstrb;
        logic [NM-1:0] req, oth;
        int            win, o, kind;

        @(negedge clk);
        for (int i = 0; i < NM; i++) begin
            h_aw[i] = m_awvalid[i] & o_awready[i];
            h_w[i]  = m_wvalid[i] & o_wready[i];
            h_b[i]  = o_bvalid[i] & m_bready[i];
            h_ar[i] = m_arvalid[i] & o_arready[i];
            h_r[i]  = o_rvalid[i] & m_rready[i];
            c_bv[i] = o_bvalid[i];
        end
        sh_aw = s_if.awvalid & s_awready;
        sh_w  = s_if.wvalid & s_wready;
        sh_b  = s_bvalid & s_if.bready;
        sh_ar = s_if.arvalid & s_arready;
        sh_r  = s_rvalid & s_if.rready;
        c_awaddr = s_if.awaddr; c_wdata = s_if.wdata; c_wstrb = s_if.wstrb;
        c_araddr = s_if.araddr;

        if (!mdl_busy) begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_up", 32'({o_awready, o_wready, o_arready, o_bvalid, o_rvalid}), 32'd0);
            chk("idle_down", 32'({s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready,
                                  s_if.rready}), 32'd0);
            req = m_awvalid | m_arvalid;
            if (req != '0) begin
                win = -1;
                for (int k = 0; k < NM; k++)
                    if (win < 0 && req[(mdl_ptr + k) % NM]) win = (mdl_ptr + k) % NM;
                mdl_busy  = 1'b1;
                mdl_owner = win;
                mdl_write = m_awvalid[win];
                just_arb  = 1'b1;
                busy_cnt  = 0;
            end
        end else begin
            o = mdl_owner;
            if (just_arb) begin
                dut_grants.push_back(grant);
                just_arb = 1'b0;
            end
            chk("grant", 32'(grant), 32'(o));
            chk("busy", 32'(busy), 32'd1);
            oth = ~(NM'(1) << o);
            chk("others_up", 32'({o_awready & oth, o_wready & oth, o_arready & oth,
                                  o_bvalid & oth, o_rvalid & oth}), 32'd0);
            if (mdl_write) chk("no_ar_leak", 32'(s_if.arvalid), 32'd0);
            else           chk("no_aw_leak", 32'({s_if.awvalid, s_if.wvalid}), 32'd0);
            if (sh_aw) chk("awaddr", c_awaddr, 32'(wr_word[o] * 4));
            if (sh_w) begin
                chk("wdata", c_wdata, wr_data[o]);
                chk("wstrb", 32'(c_wstrb), 32'(wr_strb[o]));
            end
            if (sh_ar) chk("araddr", c_araddr, 32'(rd_word[o] * 4));
            if (h_b[o]) begin
                chk("b_is_write", 32'(mdl_write), 32'd1);
                chk("bresp", 32'(o_bresp[o]), 32'(s_bresp));
                ref_mem[wr_word[o]] = merge(ref_mem[wr_word[o]], wr_data[o], wr_strb[o]);
                mdl_busy = 1'b0;
                mdl_ptr  = (o + 1) % NM;
                n_done++;
            end else if (h_r[o]) begin
                chk("r_is_read", 32'(mdl_write), 32'd0);
                chk("rdata", o_rdata[o], ref_mem[rd_word[o]]);
                chk("rresp", 32'(o_rresp[o]), 32'(s_rresp));
                mdl_busy = 1'b0;
                mdl_ptr  = (o + 1) % NM;
                n_done++;
            end
            busy_cnt++;
            if (busy_cnt == 300) chk("stall", 32'(busy_cnt), 32'd0);
        end

        @(posedge clk); #1;
        for (int i = 0; i < NM; i++) begin
            if (h_aw[i]) m_awvalid[i] = 1'b0;
            if (h_w[i])  m_wvalid[i]  = 1'b0;
            if (h_ar[i]) m_arvalid[i] = 1'b0;
            if (h_r[i])  rd_pend[i]   = 1'b0;
            if (h_b[i]) begin
                wr_pend[i] = 1'b0;
                b_wait[i]  = 0;
            end else if (c_bv[i]) begin
                b_wait[i]++;
            end
            if (!wr_pend[i] && !rd_pend[i] && $urandom_range(99) < pct_issue) begin
                kind = (kind_mode < 0) ? int'($urandom_range(2)) : kind_mode;
                if (kind != 1) begin
                    wr_pend[i]   = 1'b1;
                    wr_word[i]   = int'($urandom_range(7));
                    wr_data[i]   = $urandom;
                    wr_strb[i]   = 4'($urandom_range(15, 1));
                    m_awaddr[i]  = 32'(wr_word[i] * 4);
                    m_wdata[i]   = wr_data[i];
                    m_wstrb[i]   = wr_strb[i];
                    m_awvalid[i] = 1'b1;
                    m_wvalid[i]  = 1'b1;
                end
                if (kind != 0) begin
                    rd_pend[i]   = 1'b1;
                    rd_word[i]   = int'($urandom_range(7));
                    m_araddr[i]  = 32'(rd_word[i] * 4);
                    m_arvalid[i] = 1'b1;
                end
            end
            m_bready[i] = (b_wait[i] >= b_hold) && ($urandom_range(99) < pct_mready);
            m_rready[i] = ($urandom_range(99) < pct_mready);
        end

        if (sh_aw) begin s_aw_got = 1'b1; s_awaddr_l = c_awaddr; end
        if (sh_w)  begin s_w_got = 1'b1; s_wdata_l = c_wdata; s_wstrb_l = c_wstrb; end
        if (s_aw_got && s_w_got) begin
            s_mem[s_awaddr_l[4:2]] = merge(s_mem[s_awaddr_l[4:2]], s_wdata_l, s_wstrb_l);
            s_aw_got = 1'b0; s_w_got = 1'b0;
            s_b_pend = 1'b1; s_b_dly = int'($urandom_range(max_dly));
        end
        if (sh_b) begin
            s_bvalid = 1'b0; s_b_pend = 1'b0;
        end else if (s_b_pend && !s_bvalid) begin
            if (s_b_dly == 0) begin
                s_bvalid = 1'b1;
                s_bresp  = ($urandom_range(1) == 1) ? 2'b10 : 2'b00;
            end else begin
                s_b_dly--;
            end
        end
        if (sh_ar) begin
            s_r_pend = 1'b1;
            s_rdata  = s_mem[c_araddr[4:2]];
            s_rresp  = ($urandom_range(1) == 1) ? 2'b10 : 2'b00;
            s_r_dly  = int'($urandom_range(max_dly));
        end
        if (sh_r) begin
            s_rvalid = 1'b0; s_r_pend = 1'b0;
        end else if (s_r_pend && !s_rvalid) begin
            if (s_r_dly == 0) s_rvalid = 1'b1;
            else s_r_dly--;
        end
        s_awready = !s_aw_got && !s_b_pend && ($urandom_range(99) < pct_sready);
        s_wready  = !s_w_got && !s_b_pend && ($urandom_range(99) < pct_sready);
        s_arready = !s_r_pend && ($urandom_range(99) < pct_sready);
    endtask

    initial begin
        int found;
        for (int w = 0; w < 8; w++) begin
            s_mem[w]   = '0;
            ref_mem[w] = '0;
        end
        n_done = 0;
        clear_tb();
        do_reset();

        // every master keeps a read pending: grants must rotate 0,1,2,0,1,2
        pct_issue = 100; kind_mode = 1; pct_sready = 100; pct_mready = 100;
        max_dly = 0; b_hold = 0;
        dut_grants.delete();
        repeat (40) step();
        chk("order_len", 32'(dut_grants.size() >= 6), 32'd1);
        for (int k = 0; k < 6 && k < dut_grants.size(); k++)
            chk("order", 32'(dut_grants[k]), 32'(k % NM));

        // writes whose B is held off for ten cycles by the master
        do_reset();
        kind_mode = 0; b_hold = 10; max_dly = 2; pct_sready = 50;
        repeat (200) step();

        // mixed random traffic, including simultaneous AW+AR from one master
        do_reset();
        kind_mode = -1; b_hold = 0; pct_issue = 40; pct_sready = 60; pct_mready = 70;
        max_dly = 3;
        repeat (3000) step();

        // reset while a read response is waiting for rready
        do_reset();
        kind_mode = 1; pct_issue = 100; pct_sready = 100; pct_mready = 0; max_dly = 1;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            step();
            if (mdl_busy && !mdl_write && s_rvalid) found = 1;
        end
        chk("rdata_pending_reached", 32'(found), 32'd1);
        do_reset();

        kind_mode = -1; pct_issue = 50; pct_sready = 70; pct_mready = 80; max_dly = 2;
        repeat (500) step();
        chk("txn_count", 32'(n_done > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
